// File: rtl/retro_catc_pkg.sv
// ---------------------------------------------------------------------------
// retro_catc_pkg
// Shared types and helpers for the multi-channel CATC clock-enable generator.
//   catc_state_e     : per-channel operating state
//   MaxAccWidth      : widest accumulator the boost helper can handle
//   boost_increment  : Increment * (BoostFactor - 1), formed with 3 guard bits
//                      and truncated to the accumulator width
// ---------------------------------------------------------------------------
package retro_catc_pkg;

    localparam int unsigned MaxAccWidth = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        CATCHUP
    } catc_state_e;

    // The product is formed with three guard bits so that BoostFactor up to 8
    // cannot overflow the intermediate value. Only the low bits feed the
    // accumulator, which wraps modulo its width anyway.
    function automatic logic [MaxAccWidth-1:0] boost_increment(
        input logic [MaxAccWidth-1:0] increment,
        input int unsigned            boostFactor
    );
        logic [MaxAccWidth+2:0] wideInc;
        logic [MaxAccWidth+2:0] wideMul;
        wideInc = {3'b000, increment};
        wideMul = (MaxAccWidth+3)'(boostFactor - 1);
        return MaxAccWidth'(wideInc * wideMul);
    endfunction

endpackage

// File: rtl/retro_catc_multi_channel.sv
// ---------------------------------------------------------------------------
// retro_catc_channel
// One clock-enable channel: nominal and boost phase accumulators, the
// IDLE/RUN/STALL/CATCHUP state machine and the saturating debt counter.
// Ports:
//   Clk, Reset        : core clock, synchronous active-high reset
//   i_ClkEn           : global advance enable, low freezes the channel
//   i_Enable          : channel run enable
//   i_Increment       : nominal rate as a fraction of 2^AccWidth
//   i_EffDelay        : stall request after lockstep fan-in
//   i_ClearOverflow   : clears the sticky overflow flag
//   o_ClkEnOut        : registered one-Clk tick pulse
//   o_Debt            : current debt (ticks owed)
//   o_CatchingUp      : high while repaying debt
//   o_Overflow        : sticky, debt saturated
// ---------------------------------------------------------------------------
module retro_catc_channel
    import retro_catc_pkg::*;
#(
    parameter int unsigned AccWidth    = 32,
    parameter int unsigned DebtWidth   = 16,
    parameter int unsigned BoostFactor = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_ClkEn,
    input  logic                 i_Enable,
    input  logic [AccWidth-1:0]  i_Increment,
    input  logic                 i_EffDelay,
    input  logic                 i_ClearOverflow,
    output logic                 o_ClkEnOut,
    output logic [DebtWidth-1:0] o_Debt,
    output logic                 o_CatchingUp,
    output logic                 o_Overflow
);

    // Boost accumulator starts half a turn ahead so boost carries fall
    // between nominal carries instead of colliding with them.
    localparam logic [AccWidth-1:0]  BAccInit = {1'b1, {(AccWidth-1){1'b0}}};
    localparam logic [DebtWidth-1:0] DebtMax  = '1;

    catc_state_e            r_State;
    logic [AccWidth-1:0]    r_NAcc;
    logic [AccWidth-1:0]    r_BAcc;
    logic [DebtWidth-1:0]   r_Debt;
    logic                   r_Tick;
    logic                   r_Overflow;

    catc_state_e            w_NextState;
    logic [AccWidth-1:0]    w_NextNAcc;
    logic [AccWidth-1:0]    w_NextBAcc;
    logic [DebtWidth-1:0]   w_NextDebt;
    logic                   w_NextTick;
    logic                   w_SetOverflow;

    logic [AccWidth-1:0]    w_BoostInc;
    logic [AccWidth:0]      w_NSum;
    logic [AccWidth:0]      w_BSum;
    logic                   w_NomCarry;
    logic                   w_BoostCarry;

    assign w_BoostInc   = AccWidth'(boost_increment(MaxAccWidth'(i_Increment), BoostFactor));
    assign w_NSum       = {1'b0, r_NAcc} + {1'b0, i_Increment};
    assign w_BSum       = {1'b0, r_BAcc} + {1'b0, w_BoostInc};
    assign w_NomCarry   = w_NSum[AccWidth];
    assign w_BoostCarry = w_BSum[AccWidth];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_State    <= IDLE;
            r_NAcc     <= '0;
            r_BAcc     <= BAccInit;
            r_Debt     <= '0;
            r_Tick     <= 1'b0;
            r_Overflow <= 1'b0;
        end else begin
            r_State    <= w_NextState;
            r_NAcc     <= w_NextNAcc;
            r_BAcc     <= w_NextBAcc;
            r_Debt     <= w_NextDebt;
            r_Tick     <= w_NextTick;
            // A saturation in the same cycle as a clear keeps the flag set.
            r_Overflow <= w_SetOverflow | (r_Overflow & ~i_ClearOverflow);
        end
    end

    always_comb begin
        w_NextState   = r_State;
        w_NextNAcc    = r_NAcc;
        w_NextBAcc    = r_BAcc;
        w_NextDebt    = r_Debt;
        w_NextTick    = 1'b0;
        w_SetOverflow = 1'b0;

        if (i_ClkEn) begin
            if (!i_Enable) begin
                w_NextState = IDLE;
                w_NextNAcc  = '0;
                w_NextBAcc  = BAccInit;
                w_NextDebt  = '0;
            end else begin
                if (r_State != IDLE) begin
                    w_NextNAcc = w_NSum[AccWidth-1:0];
                    w_NextBAcc = w_BSum[AccWidth-1:0];
                end

                unique case (r_State)
                    IDLE: begin
                        w_NextState = RUN;
                    end
                    RUN: begin
                        w_NextTick = w_NomCarry;
                        if (i_EffDelay) begin
                            w_NextState = STALL;
                        end
                    end
                    STALL: begin
                        if (w_NomCarry) begin
                            if (r_Debt == DebtMax) begin
                                w_SetOverflow = 1'b1;
                            end else begin
                                w_NextDebt = r_Debt + DebtWidth'(1);
                            end
                        end
                        // Release decision uses the debt after this cycle's update.
                        if (!i_EffDelay) begin
                            w_NextState = (w_NextDebt != '0) ? CATCHUP : RUN;
                        end
                    end
                    CATCHUP: begin
                        // A boost carry coinciding with a nominal carry is dropped,
                        // so the channel never emits two ticks in one Clk.
                        if (w_NomCarry) begin
                            w_NextTick = 1'b1;
                        end else if (w_BoostCarry && (r_Debt != '0)) begin
                            w_NextTick = 1'b1;
                            w_NextDebt = r_Debt - DebtWidth'(1);
                        end
                        if (i_EffDelay) begin
                            w_NextState = STALL;
                        end else if (w_NextDebt == '0) begin
                            w_NextState = RUN;
                        end
                    end
                endcase
            end
        end
    end

    assign o_ClkEnOut   = r_Tick;
    assign o_Debt       = r_Debt;
    assign o_CatchingUp = (r_State == CATCHUP);
    assign o_Overflow   = r_Overflow;

endmodule

// File: rtl/retro_catc_multi.sv
// ---------------------------------------------------------------------------
// retro_catc_multi
// Multi-channel fractional clock-enable generator with stall debt and boosted
// catch-up. Forms each channel's effective delay (optionally in lockstep) and
// instantiates one retro_catc_channel per channel.
// Ports:
//   Clk, Reset        : core clock, synchronous active-high reset
//   i_ClkEn           : global advance enable
//   i_Enable          : per-channel run enable
//   i_Increment       : per-channel nominal rate (fraction of 2^AccWidth)
//   i_Delay           : per-channel stall request
//   i_Lockstep        : any enabled channel's delay stalls all channels
//   i_ClearOverflow   : clears all overflow flags
//   o_ClkEnOut        : per-channel tick pulse
//   o_Debt            : per-channel debt
//   o_CatchingUp      : per-channel catch-up indicator
//   o_Overflow        : per-channel sticky debt saturation flag
// ---------------------------------------------------------------------------
module retro_catc_multi
    import retro_catc_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AccWidth    = 32,
    parameter int unsigned DebtWidth   = 16,
    parameter int unsigned BoostFactor = 2
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  i_ClkEn,
    input  logic [NumChannels-1:0]                i_Enable,
    input  logic [NumChannels-1:0][AccWidth-1:0]  i_Increment,
    input  logic [NumChannels-1:0]                i_Delay,
    input  logic                                  i_Lockstep,
    input  logic                                  i_ClearOverflow,
    output logic [NumChannels-1:0]                o_ClkEnOut,
    output logic [NumChannels-1:0][DebtWidth-1:0] o_Debt,
    output logic [NumChannels-1:0]                o_CatchingUp,
    output logic [NumChannels-1:0]                o_Overflow
);

    // Disabled channels must not hold the others hostage in lockstep mode.
    logic                   w_AnyDelay;
    logic [NumChannels-1:0] w_EffDelay;

    assign w_AnyDelay = |(i_Delay & i_Enable);

    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_channel
        assign w_EffDelay[ch] = i_Lockstep ? w_AnyDelay : i_Delay[ch];

        retro_catc_channel #(
            .AccWidth    (AccWidth),
            .DebtWidth   (DebtWidth),
            .BoostFactor (BoostFactor)
        ) u_channel (
            .Clk             (Clk),
            .Reset           (Reset),
            .i_ClkEn         (i_ClkEn),
            .i_Enable        (i_Enable[ch]),
            .i_Increment     (i_Increment[ch]),
            .i_EffDelay      (w_EffDelay[ch]),
            .i_ClearOverflow (i_ClearOverflow),
            .o_ClkEnOut      (o_ClkEnOut[ch]),
            .o_Debt          (o_Debt[ch]),
            .o_CatchingUp    (o_CatchingUp[ch]),
            .o_Overflow      (o_Overflow[ch])
        );
    end

endmodule
